modmul_rr_scheduler: RTL

//   Shares one pipelined modular_mul (q=3329, fixed latency LAT) between
//   NUM_REQ requesters (e.g. butterfly lanes, twiddle precompute) using

---
 rtl/modmul_rr_scheduler.sv | 73 +++++++
 1 files changed

// File: rtl/modmul_rr_scheduler.sv
// modmul_rr_scheduler: round-robin front end sharing one pipelined modular multiplier
// between NUM_REQ requesters; a tag pipe returns each product with its owner's ID.
module modmul_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DW = 12,
    parameter int LAT = 6,
    parameter int IDW = $clog2(NUM_REQ),
    localparam int CW = $clog2(LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  hold,
    output logic [DW-1:0]         mul_a,
    output logic [DW-1:0]         mul_b,
    input  logic [DW-1:0]         mul_p,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW-1:0]         rsp_data,
    output logic [CW-1:0]         inflight,
    output logic                  idle
);

    logic [IDW-1:0]          rr_ptr;
    logic                    grant;
    logic [IDW-1:0]          gnt_id;
    logic [IDW:0]            cand;
    logic [LAT-1:0]          tag_v;
    logic [LAT-1:0][IDW-1:0] tag_id;

    // Scan lanes starting at rr_ptr, wrapping modulo NUM_REQ; first valid lane wins.
    always_comb begin
        grant = 1'b0;
        gnt_id = '0;
        cand = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = {1'b0, rr_ptr} + (IDW + 1)'(j);
            if (cand >= (IDW + 1)'(NUM_REQ)) cand = cand - (IDW + 1)'(NUM_REQ);
            if (!grant && !hold && req_valid[cand[IDW-1:0]]) begin
                grant = 1'b1;
                gnt_id = cand[IDW-1:0];
            end
        end
    end

    assign req_ready = grant ? (NUM_REQ'(1) << gnt_id) : '0;
    assign mul_a     = grant ? req_a[gnt_id*DW +: DW] : '0;
    assign mul_b     = grant ? req_b[gnt_id*DW +: DW] : '0;

    // The multiplier never stalls, so the tag pipe shifts every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            tag_v    <= '0;
            tag_id   <= '0;
            inflight <= '0;
        end else begin
            if (grant) rr_ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
            tag_v    <= {tag_v[LAT-2:0], grant};
            tag_id   <= {tag_id[LAT-2:0], gnt_id};
            inflight <= inflight + CW'(grant) - CW'(rsp_valid);
        end
    end

    assign rsp_valid = tag_v[LAT-1];
    assign rsp_id    = tag_id[LAT-1];
    assign rsp_data  = mul_p;
    assign idle      = (inflight == '0);

endmodule
